// File: rtl/logic_operand_fetch_if.sv
// ---------------------------------------------------------------------------
// logic_operand_fetch_if
//
// Bundles the three channels of the logic-unit operand fetch stage:
//   - instruction handshake : instr_valid, instr_ready, instr[18:0]
//   - register file port    : rf_raddr, rf_re, rf_rdata
//   - logic unit handshake  : lu_a, lu_b, lu_opcode, lu_rd, lu_valid, lu_ready
//   - status                : illegal (one-cycle pulse)
//
// Modports:
//   master : the operand fetch block itself (drives rf_*, lu_*, instr_ready,
//            illegal; receives instr_*, rf_rdata, lu_ready)
//   slave  : the surrounding environment (issue queue, register file and
//            logic unit seen as one agent)
// ---------------------------------------------------------------------------
interface logic_operand_fetch_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);

  // Instruction channel
  logic              instr_valid;
  logic              instr_ready;
  logic [18:0]       instr;

  // Register file read port (synchronous, one cycle read latency)
  logic [REG_AW-1:0] rf_raddr;
  logic              rf_re;
  logic [DATA_W-1:0] rf_rdata;

  // Logic unit channel
  logic [DATA_W-1:0] lu_a;
  logic [DATA_W-1:0] lu_b;
  logic [2:0]        lu_opcode;
  logic [REG_AW-1:0] lu_rd;
  logic              lu_valid;
  logic              lu_ready;

  // Status
  logic              illegal;

  modport master (
    input  instr_valid,
    input  instr,
    input  rf_rdata,
    input  lu_ready,
    output instr_ready,
    output rf_raddr,
    output rf_re,
    output lu_a,
    output lu_b,
    output lu_opcode,
    output lu_rd,
    output lu_valid,
    output illegal
  );

  modport slave (
    output instr_valid,
    output instr,
    output rf_rdata,
    output lu_ready,
    input  instr_ready,
    input  rf_raddr,
    input  rf_re,
    input  lu_a,
    input  lu_b,
    input  lu_opcode,
    input  lu_rd,
    input  lu_valid,
    input  illegal
  );

endinterface

// File: rtl/logic_operand_fetch.sv
// ---------------------------------------------------------------------------
// logic_operand_fetch
//
// Issue stage in front of the 16-bit logic unit. Accepts one 19-bit
// instruction per handshake, decodes the logic-class major opcode, reads the
// source operands one per cycle through the single synchronous register file
// read port and presents a/b/opcode/rd to the logic unit behind valid/ready.
//
// Instruction layout: [18:15] major, [14:11] rd, [10:7] rs1, [6:3] rs2,
//                     [2:0] reserved (ignored).
// Major opcode 0100/0101/0110/0111 -> lu_opcode AND/OR/XOR/NOT (000..011);
// every other major is illegal: consumed, flagged on `illegal` for one cycle,
// no register file read, lu_* untouched.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : logic_operand_fetch_if.master (instr_*, rf_*, lu_*, illegal)
//
// Optional feature (macro LOGIC_FETCH_R0_ZERO_EN):
//   when defined, a source operand whose register address is 0 is captured
//   as zero regardless of rf_rdata. Read strobes and timing are unchanged.
//
// Timing from the acceptance edge: lu_valid rises after 3 edges (2 for NOT);
// fetch never overlaps ISSUE, so the issue interval is 5 cycles (4 for NOT).
// The field layout of instr assumes REG_AW == 4.
// ---------------------------------------------------------------------------
module logic_operand_fetch #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  logic_operand_fetch_if.master  bus
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD_A  = 3'd1;
  localparam logic [2:0] ST_RD_B  = 3'd2;
  localparam logic [2:0] ST_CAP_B = 3'd3;
  localparam logic [2:0] ST_ISSUE = 3'd4;

  localparam logic [2:0] OP_NOT = 3'b011;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [2:0]        state_q,     state_d;
  logic [REG_AW-1:0] rd_q,        rd_d;
  logic [REG_AW-1:0] rs1_q,       rs1_d;
  logic [REG_AW-1:0] rs2_q,       rs2_d;
  logic [2:0]        op_q,        op_d;

  logic [REG_AW-1:0] rf_raddr_q,  rf_raddr_d;
  logic              rf_re_q,     rf_re_d;
  logic [DATA_W-1:0] lu_a_q,      lu_a_d;
  logic [DATA_W-1:0] lu_b_q,      lu_b_d;
  logic [2:0]        lu_opcode_q, lu_opcode_d;
  logic [REG_AW-1:0] lu_rd_q,     lu_rd_d;
  logic              lu_valid_q,  lu_valid_d;
  logic              illegal_q,   illegal_d;

  // -------------------------------------------------------------------------
  // Decode of the incoming instruction word
  // -------------------------------------------------------------------------
  logic [3:0]        major;
  logic [REG_AW-1:0] f_rd;
  logic [REG_AW-1:0] f_rs1;
  logic [REG_AW-1:0] f_rs2;
  logic              is_logic;
  logic [2:0]        dec_op;
  logic              instr_ready;
  logic              accept;
  logic              unused_reserved;

  assign major  = bus.instr[18:15];
  assign f_rd   = bus.instr[14:11];
  assign f_rs1  = bus.instr[10:7];
  assign f_rs2  = bus.instr[6:3];
  assign unused_reserved = ^bus.instr[2:0];

  // Logic class is exactly 01xx; the low two bits select the operation.
  assign is_logic = (major[3:2] == 2'b01);
  assign dec_op   = {1'b0, major[1:0]};

  // Held low during reset so nothing is accepted on the reset edge.
  assign instr_ready = (state_q == ST_IDLE) && !rst;
  assign accept      = bus.instr_valid && instr_ready;

  // -------------------------------------------------------------------------
  // Operand capture values. rf_rdata always belongs to the read issued one
  // cycle earlier: rs1 while in RD_B, rs2 while in CAP_B.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] opa_cap;
  logic [DATA_W-1:0] opb_cap;

`ifdef LOGIC_FETCH_R0_ZERO_EN
  assign opa_cap = (rs1_q == '0) ? '0 : bus.rf_rdata;
  assign opb_cap = (rs2_q == '0) ? '0 : bus.rf_rdata;
`else
  assign opa_cap = bus.rf_rdata;
  assign opb_cap = bus.rf_rdata;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    op_d        = op_q;
    rf_raddr_d  = rf_raddr_q;
    rf_re_d     = rf_re_q;
    lu_a_d      = lu_a_q;
    lu_b_d      = lu_b_q;
    lu_opcode_d = lu_opcode_q;
    lu_rd_d     = lu_rd_q;
    lu_valid_d  = lu_valid_q;
    illegal_d   = 1'b0;   // pulse: only ever high for one cycle

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_logic) begin
            rd_d       = f_rd;
            rs1_d      = f_rs1;
            rs2_d      = f_rs2;
            op_d       = dec_op;
            rf_raddr_d = f_rs1;
            rf_re_d    = 1'b1;
            state_d    = ST_RD_A;
          end else begin
            // Consumed but not executed; lu_* keep their previous values.
            illegal_d  = 1'b1;
          end
        end
      end

      ST_RD_A: begin
        // RF samples rs1 on this edge; queue the rs2 read unless unary.
        if (op_q == OP_NOT) begin
          rf_re_d    = 1'b0;
        end else begin
          rf_raddr_d = rs2_q;
          rf_re_d    = 1'b1;
        end
        state_d = ST_RD_B;
      end

      ST_RD_B: begin
        lu_a_d      = opa_cap;
        // lu_valid is low here, so the tag and opcode can be loaded early.
        lu_opcode_d = op_q;
        lu_rd_d     = rd_q;
        if (op_q == OP_NOT) begin
          lu_b_d     = '0;
          lu_valid_d = 1'b1;
          state_d    = ST_ISSUE;
        end else begin
          rf_re_d    = 1'b0;
          state_d    = ST_CAP_B;
        end
      end

      ST_CAP_B: begin
        lu_b_d     = opb_cap;
        lu_valid_d = 1'b1;
        state_d    = ST_ISSUE;
      end

      ST_ISSUE: begin
        // lu_valid is always high in this state; ready alone completes it.
        if (bus.lu_ready) begin
          lu_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        lu_valid_d = 1'b0;
        rf_re_d    = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers. Reset discards any in-flight instruction in every state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      op_q        <= '0;
      rf_raddr_q  <= '0;
      rf_re_q     <= 1'b0;
      lu_a_q      <= '0;
      lu_b_q      <= '0;
      lu_opcode_q <= '0;
      lu_rd_q     <= '0;
      lu_valid_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      op_q        <= op_d;
      rf_raddr_q  <= rf_raddr_d;
      rf_re_q     <= rf_re_d;
      lu_a_q      <= lu_a_d;
      lu_b_q      <= lu_b_d;
      lu_opcode_q <= lu_opcode_d;
      lu_rd_q     <= lu_rd_d;
      lu_valid_q  <= lu_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.instr_ready = instr_ready;
  assign bus.rf_raddr    = rf_raddr_q;
  assign bus.rf_re       = rf_re_q;
  assign bus.lu_a        = lu_a_q;
  assign bus.lu_b        = lu_b_q;
  assign bus.lu_opcode   = lu_opcode_q;
  assign bus.lu_rd       = lu_rd_q;
  assign bus.lu_valid    = lu_valid_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_logic_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_logic_operand_fetch
//
// Directed bench for logic_operand_fetch. A small register file model with a
// one-cycle registered read answers the fetch port; expected values are
// hand-computed constants. Honours LOGIC_FETCH_R0_ZERO_EN for the R0 case.
// ---------------------------------------------------------------------------
module tb_logic_operand_fetch;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic_operand_fetch_if #(.DATA_W(16), .REG_AW(4)) bus ();

  logic_operand_fetch #(.DATA_W(16), .REG_AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file model: synchronous read, data valid the cycle after re.
  logic [15:0] rf_mem [16];

  always @(posedge clk) begin
    if (bus.rf_re) bus.rf_rdata <= rf_mem[bus.rf_raddr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] mk(input logic [3:0] major, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2);
    return {major, rd, rs1, rs2, 3'b000};
  endfunction

  // Present one instruction for one edge; the bus is then scrambled to show
  // it is only sampled at acceptance.
  task automatic accept(input logic [18:0] w);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    check_val("accept_ready", bus.instr_ready, 1'b1);
    tick();
    bus.instr_valid = 1'b0;
    bus.instr       = 19'h7FFFF;
  endtask

  // Full operation with latency measurement and immediate consumption.
  task automatic run_op(input string tag, input logic [18:0] w,
                        input logic [15:0] exp_a, input logic [15:0] exp_b,
                        input logic [2:0] exp_op, input logic [3:0] exp_rd,
                        input int exp_lat);
    int n;
    accept(w);
    n = 0;
    while (!bus.lu_valid && n < 10) begin
      tick();
      n++;
    end
    check_val({tag, "_lat"}, n, exp_lat);
    check_val({tag, "_a"}, bus.lu_a, exp_a);
    check_val({tag, "_b"}, bus.lu_b, exp_b);
    check_val({tag, "_op"}, bus.lu_opcode, exp_op);
    check_val({tag, "_rd"}, bus.lu_rd, exp_rd);
    bus.lu_ready = 1'b1;
    tick();
    bus.lu_ready = 1'b0;
    check_val({tag, "_done_valid"}, bus.lu_valid, 1'b0);
    check_val({tag, "_done_ready"}, bus.instr_ready, 1'b1);
    $display("txn %s: lat=%0d a=%h b=%h op=%0d rd=%0d", tag, n, bus.lu_a,
             bus.lu_b, bus.lu_opcode, bus.lu_rd);
  endtask

  logic [3:0]  bad_major [3];
  logic [15:0] exp_r0_a;

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 16'h0000;
    rf_mem[0]  = 16'hFFFF;
    rf_mem[2]  = 16'hF0F0;
    rf_mem[3]  = 16'h0FF0;
    rf_mem[4]  = 16'h00FF;
    rf_mem[5]  = 16'h1234;
    rf_mem[7]  = 16'hA5A5;
    rf_mem[8]  = 16'hFF00;
    rf_mem[11] = 16'h0F00;
    rf_mem[12] = 16'h00F0;

    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.lu_ready    = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    check_val("rst_lu_valid", bus.lu_valid, 1'b0);
    check_val("rst_illegal", bus.illegal, 1'b0);
    check_val("rst_rf_re", bus.rf_re, 1'b0);
    check_val("rst_rf_raddr", bus.rf_raddr, 4'd0);
    check_val("rst_lu_a", bus.lu_a, 16'h0000);
    check_val("rst_instr_ready", bus.instr_ready, 1'b0);
    rst = 1'b0;
    #1;
    check_val("post_rst_ready", bus.instr_ready, 1'b1);
    $display("txn reset: done");

    // ---- AND, edge by edge ----
    accept(mk(4'b0100, 4'd1, 4'd2, 4'd3));
    check_val("and_e0_raddr", bus.rf_raddr, 4'd2);
    check_val("and_e0_re", bus.rf_re, 1'b1);
    check_val("and_e0_ready", bus.instr_ready, 1'b0);
    tick();
    check_val("and_e1_raddr", bus.rf_raddr, 4'd3);
    check_val("and_e1_re", bus.rf_re, 1'b1);
    check_val("and_e1_valid", bus.lu_valid, 1'b0);
    tick();
    check_val("and_e2_re", bus.rf_re, 1'b0);
    check_val("and_e2_valid", bus.lu_valid, 1'b0);
    tick();
    check_val("and_e3_valid", bus.lu_valid, 1'b1);
    check_val("and_a", bus.lu_a, 16'hF0F0);
    check_val("and_b", bus.lu_b, 16'h0FF0);
    check_val("and_op", bus.lu_opcode, 3'b000);
    check_val("and_rd", bus.lu_rd, 4'd1);
    bus.lu_ready = 1'b1;
    tick();
    bus.lu_ready = 1'b0;
    check_val("and_done_valid", bus.lu_valid, 1'b0);
    check_val("and_done_ready", bus.instr_ready, 1'b1);
    $display("txn AND: a=%h b=%h", 16'hF0F0, 16'h0FF0);

    // ---- NOT, lu_ready already high when lu_valid rises ----
    accept(mk(4'b0111, 4'd6, 4'd5, 4'd9));
    check_val("not_e0_re", bus.rf_re, 1'b1);
    check_val("not_e0_raddr", bus.rf_raddr, 4'd5);
    bus.lu_ready = 1'b1;
    tick();
    check_val("not_e1_re", bus.rf_re, 1'b0);
    check_val("not_e1_raddr", bus.rf_raddr, 4'd5);
    check_val("not_e1_valid", bus.lu_valid, 1'b0);
    tick();
    check_val("not_e2_valid", bus.lu_valid, 1'b1);
    check_val("not_a", bus.lu_a, 16'h1234);
    check_val("not_b", bus.lu_b, 16'h0000);
    check_val("not_op", bus.lu_opcode, 3'b011);
    check_val("not_rd", bus.lu_rd, 4'd6);
    tick();
    bus.lu_ready = 1'b0;
    check_val("not_done_valid", bus.lu_valid, 1'b0);
    check_val("not_done_ready", bus.instr_ready, 1'b1);
    $display("txn NOT: a=%h", 16'h1234);

    // ---- XOR with 4 cycles of backpressure ----
    accept(mk(4'b0110, 4'd10, 4'd7, 4'd8));
    tick();
    tick();
    tick();
    check_val("xor_valid", bus.lu_valid, 1'b1);
    bus.instr_valid = 1'b1;
    bus.instr       = mk(4'b0100, 4'd1, 4'd2, 4'd3);
    for (int i = 0; i < 4; i++) begin
      check_val("xor_bp_ready", bus.instr_ready, 1'b0);
      tick();
      check_val("xor_bp_valid", bus.lu_valid, 1'b1);
      check_val("xor_bp_a", bus.lu_a, 16'hA5A5);
      check_val("xor_bp_b", bus.lu_b, 16'hFF00);
      check_val("xor_bp_op", bus.lu_opcode, 3'b010);
      check_val("xor_bp_rd", bus.lu_rd, 4'd10);
    end
    bus.instr_valid = 1'b0;
    bus.lu_ready    = 1'b1;
    tick();
    bus.lu_ready = 1'b0;
    check_val("xor_done_valid", bus.lu_valid, 1'b0);
    check_val("xor_done_ready", bus.instr_ready, 1'b1);
    check_val("xor_done_re", bus.rf_re, 1'b0);
    $display("txn XOR: backpressure 4 cycles");

    // ---- illegal instructions ----
    accept(mk(4'b1010, 4'd1, 4'd2, 4'd3));
    check_val("ill_pulse", bus.illegal, 1'b1);
    check_val("ill_re", bus.rf_re, 1'b0);
    check_val("ill_valid", bus.lu_valid, 1'b0);
    check_val("ill_ready", bus.instr_ready, 1'b1);
    tick();
    check_val("ill_pulse_end", bus.illegal, 1'b0);
    check_val("ill_re2", bus.rf_re, 1'b0);
    check_val("ill_valid2", bus.lu_valid, 1'b0);
    check_val("ill_lu_a_kept", bus.lu_a, 16'hA5A5);
    $display("txn ILLEGAL major=1010");

    bad_major[0] = 4'b0000;
    bad_major[1] = 4'b0011;
    bad_major[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      accept(mk(bad_major[i], 4'd1, 4'd2, 4'd3));
      check_val("ill_edge_pulse", bus.illegal, 1'b1);
      check_val("ill_edge_re", bus.rf_re, 1'b0);
      tick();
      check_val("ill_edge_end", bus.illegal, 1'b0);
      $display("txn ILLEGAL major=%b", bad_major[i]);
    end

    // ---- OR after illegal ----
    run_op("or", mk(4'b0101, 4'd3, 4'd11, 4'd12), 16'h0F00, 16'h00F0,
           3'b001, 4'd3, 3);

    // ---- rs1 == rs2 ----
    run_op("and_same", mk(4'b0100, 4'd9, 4'd7, 4'd7), 16'hA5A5, 16'hA5A5,
           3'b000, 4'd9, 3);

    // ---- reset during CAP_B ----
    accept(mk(4'b0100, 4'd4, 4'd2, 4'd3));
    tick();
    tick();
    check_val("rmid_in_capb_valid", bus.lu_valid, 1'b0);
    check_val("rmid_pre_a", bus.lu_a, 16'hF0F0);
    rst = 1'b1;
    tick();
    check_val("rmid_valid", bus.lu_valid, 1'b0);
    check_val("rmid_a", bus.lu_a, 16'h0000);
    check_val("rmid_b", bus.lu_b, 16'h0000);
    check_val("rmid_op", bus.lu_opcode, 3'b000);
    check_val("rmid_rd", bus.lu_rd, 4'd0);
    check_val("rmid_re", bus.rf_re, 1'b0);
    check_val("rmid_raddr", bus.rf_raddr, 4'd0);
    check_val("rmid_illegal", bus.illegal, 1'b0);
    rst = 1'b0;
    #1;
    check_val("rmid_ready", bus.instr_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("rmid_no_stale", bus.lu_valid, 1'b0);
    end
    $display("txn RESET mid-op: discarded");

    // ---- register 0 as source ----
`ifdef LOGIC_FETCH_R0_ZERO_EN
    exp_r0_a = 16'h0000;
`else
    exp_r0_a = 16'hFFFF;
`endif
    run_op("or_r0", mk(4'b0101, 4'd1, 4'd0, 4'd4), exp_r0_a, 16'h00FF,
           3'b001, 4'd1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_operand_fetch.md
Name: logic_operand_fetch

Overview:
Upstream issue stage for the 16-bit logic unit (AND/OR/XOR/NOT, 3-bit opcode, 16-bit a/b). Accepts one 19-bit instruction per handshake and decodes the logic-class opcode. Reads the source operands through the single synchronous read port of the register file, one operand per cycle. Presents a, b, opcode and destination tag to the logic unit behind a valid/ready handshake.

Parameters:
- DATA_W, 16, operand width on rf_rdata, lu_a and lu_b.
- REG_AW, 4, register address width for rd, rs1 and rs2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset, sampled on the rising edge of clk.
- instr_valid  in  1  instruction word is valid.
- instr_ready  out  1  block can accept an instruction.
- instr  in  19  instruction word. [18:15] major opcode, [14:11] rd, [10:7] rs1, [6:3] rs2, [2:0] reserved (ignored).
- rf_raddr  out  REG_AW  register file read address (registered).
- rf_re  out  1  register file read strobe.
- rf_rdata  in  DATA_W  read data; valid the cycle after rf_raddr/rf_re are presented.
- lu_a  out  DATA_W  operand a to the logic unit.
- lu_b  out  DATA_W  operand b to the logic unit.
- lu_opcode  out  3  logic unit opcode.
- lu_rd  out  REG_AW  destination register tag travelling with the operation.
- lu_valid  out  1  operands and opcode are valid.
- lu_ready  in  1  logic unit / writeback consumes the operation.
- illegal  out  1  one-cycle pulse when a non-logic instruction is accepted.

Behaviour:
- Reset: state=IDLE. All of rf_raddr, rf_re, lu_a, lu_b, lu_opcode, lu_rd, lu_valid and illegal are 0.
- instr_ready = (state==IDLE) and not rst. Acceptance means instr_valid and instr_ready high together at a clock edge.
- Decode: major opcode 0100/0101/0110/0111 map to lu_opcode 000 (AND), 001 (OR), 010 (XOR) and 011 (NOT). All other major values are illegal.
- Illegal instruction:
  - It is accepted (consumed).
  - illegal=1 for exactly the next cycle.
  - No RF read occurs; state stays IDLE; lu_* outputs are unchanged.
- State IDLE: on accepting a logic instruction, capture rd, rs1, rs2 and opcode. Set rf_raddr<=rs1, rf_re<=1, then go to RD_A.
- State RD_A: the RF samples rs1. Set rf_raddr<=rs2 and rf_re<=1, then go to RD_B. For NOT, set rf_re<=0 and leave rf_raddr at rs1.
- State RD_B: rf_rdata holds reg[rs1]; lu_a<=rf_rdata.
  - NOT: lu_b<=0, lu_valid<=1, go to ISSUE.
  - Otherwise: rf_re<=0, go to CAP_B.
- State CAP_B: lu_b<=rf_rdata (reg[rs2]), lu_valid<=1, go to ISSUE.
- State ISSUE:
  - lu_a, lu_b, lu_opcode and lu_rd are held stable while lu_valid=1.
  - On lu_valid and lu_ready: lu_valid<=0, go to IDLE.
  - lu_ready may already be high on lu_valid's first cycle. The handshake then completes that cycle.
- Latency, counted from the acceptance edge:
  - lu_valid rises 3 edges later for AND/OR/XOR and 2 edges later for NOT.
  - Minimum issue interval is 5 cycles (4 for NOT). There is no overlap of fetch with ISSUE.
- rs1==rs2: both reads are still performed; lu_a and lu_b are equal.
- Reset mid-operation, in any state: the in-flight instruction is discarded. lu_valid drops in the next cycle, with no partial issue.
- lu_ready is ignored outside ISSUE. instr_valid is ignored outside IDLE. The instr bus is only sampled at acceptance.

Optional Feature:
LOGIC_FETCH_R0_ZERO_EN:
- Defined: a source operand whose address is 0 is forced to 16'h0000 at its capture point, regardless of rf_rdata. RF read strobes and cycle timing are unchanged.
- Undefined: register 0 is an ordinary register, and its captured value is rf_rdata.

Test Plan:
- AND: R2=16'hF0F0, R3=16'h0FF0; instr={4'b0100,rd=1,rs1=2,rs2=3,3'b0}.
  - rf_raddr 2 then 3.
  - lu_valid rises 3 edges after acceptance with lu_a=F0F0, lu_b=0FF0, lu_opcode=000, lu_rd=1.
- NOT: R5=16'h1234; major 0111, rs1=5.
  - rf_re is high for only one cycle.
  - lu_valid after 2 edges with lu_a=1234, lu_b=0000, lu_opcode=011.
- Backpressure: XOR issue with lu_ready=0 for 4 cycles.
  - lu_valid and the lu_* outputs stay stable.
  - instr_ready=0 throughout.
  - On lu_ready=1 it returns to IDLE next edge; instr_ready=1.
- Illegal: major 1010 accepted.
  - illegal pulses exactly 1 cycle; rf_re stays 0; lu_valid stays 0.
  - The next OR instruction issues normally.
- Reset mid-op: rst asserted during CAP_B.
  - The next cycle has lu_valid=0, all outputs 0, and instr_ready=1 after rst deasserts.
  - No stale issue follows.
- With LOGIC_FETCH_R0_ZERO_EN defined, OR rs1=0, rs2=4 (R4=00FF) while the RF returns FFFF for address 0: lu_a=0000, lu_b=00FF. Without the macro: lu_a=FFFF.
